sprite_engine: RTL and testbench

- Parametrised successor to the fixed 64x32 CHIP-8 draw unit.
- Owns the monochrome framebuffer and executes XOR sprite draws and screen clears as multi-cycle operations, one framebuffer row per clock.
- Reports pixel collision in VF and provides a registered scan-out read port for the display path.
- Sits between the CPU's DXYN/00E0 execution and the video output.

---
 rtl/sprite_engine.sv | 170 +++++++++++++++++
 tb/tb_sprite_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// Monochrome framebuffer with multi-cycle XOR sprite draw and screen clear, one row per clock.
// Collision is reported in vf; rd_data is a registered scan-out port with pre-write semantics.
module sprite_engine #(
    parameter int unsigned SCR_W    = 64,
    parameter int unsigned SCR_H    = 32,
    parameter int unsigned MAX_ROWS = 15,
    parameter int unsigned WRAP     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    input  logic                     draw_req,
    input  logic [7:0]               row,
    input  logic [7:0]               col,
    input  logic [3:0]               height,
    input  logic [8*MAX_ROWS-1:0]    sprite_data,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               vf,
    input  logic [$clog2(SCR_H)-1:0] rd_row,
    output logic [SCR_W-1:0]         rd_data
);

    localparam int unsigned YW    = $clog2(SCR_H);
    localparam int unsigned XW    = $clog2(SCR_W);
    localparam int unsigned CW    = (YW > 4) ? YW : 4;
    localparam int unsigned SW    = YW + 5;
    localparam int unsigned SPR_W = 8 * MAX_ROWS;

    typedef enum logic [1:0] {StIdle, StClear, StDraw, StFin} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [YW-1:0]      y0_q, y0_d;
    logic [XW-1:0]      x0_q, x0_d;
    logic [3:0]         n_q, n_d;
    logic [SPR_W-1:0]   spr_q, spr_d;
    logic               vf_q, vf_d;
    logic               busy_q, done_q;
    logic [SCR_W-1:0]   rd_data_q;
    logic [SCR_W-1:0]   fb_q [SCR_H];

    logic               we;
    logic [YW-1:0]      waddr;
    logic [SCR_W-1:0]   wdata;

    logic [7:0]         rev;
    logic [2*SCR_W-1:0] ext;
    logic [SCR_W-1:0]   mask;
    logic [SW-1:0]      y_sum;
    logic [YW-1:0]      y_row;
    logic               row_ok;
    logic [3:0]         n_eff;
    logic [SCR_W-1:0]   cur_row;

    // Sprite row in flight is always the top byte of spr_q; it is shifted up each draw cycle.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            rev[j] = spr_q[SPR_W-1-j];
        end
        ext   = (2*SCR_W)'(rev) << x0_q;
        y_sum = SW'(y0_q) + SW'(cnt_q);
        y_row = y_sum[YW-1:0];
        if (WRAP != 0) begin
            mask   = ext[SCR_W-1:0] | ext[2*SCR_W-1:SCR_W];
            row_ok = 1'b1;
        end else begin
            mask   = ext[SCR_W-1:0];
            row_ok = (y_sum < SW'(SCR_H));
        end
        cur_row = fb_q[y_row];
        n_eff   = (32'(height) > MAX_ROWS) ? 4'(MAX_ROWS) : height;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y0_d    = y0_q;
        x0_d    = x0_q;
        n_d     = n_q;
        spr_d   = spr_q;
        vf_d    = vf_q;
        we      = 1'b0;
        waddr   = y_row;
        wdata   = cur_row ^ mask;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (draw_req) begin
                    state_d = StDraw;
                    cnt_d   = '0;
                    y0_d    = YW'(row);
                    x0_d    = XW'(col);
                    n_d     = n_eff;
                    spr_d   = sprite_data;
                    vf_d    = 1'b0;
                end
            end
            StClear: begin
                we    = 1'b1;
                waddr = YW'(cnt_q);
                wdata = '0;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SCR_H - 1)) begin
                    state_d = StFin;
                end
            end
            StDraw: begin
                // Clipped rows and the height=0 cycle still advance but leave fb and vf alone.
                if ((CW'(n_q) > cnt_q) && row_ok) begin
                    we = 1'b1;
                    if ((cur_row & mask) != '0) begin
                        vf_d = 1'b1;
                    end
                end
                spr_d = spr_q << 8;
                cnt_d = cnt_q + CW'(1);
                if ((cnt_q + CW'(1)) >= CW'(n_q)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            y0_q      <= '0;
            x0_q      <= '0;
            n_q       <= '0;
            spr_q     <= '0;
            vf_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            for (int r = 0; r < int'(SCR_H); r++) begin
                fb_q[r] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y0_q      <= y0_d;
            x0_q      <= x0_d;
            n_q       <= n_d;
            spr_q     <= spr_d;
            vf_q      <= vf_d;
            busy_q    <= (state_d == StClear) || (state_d == StDraw);
            done_q    <= (state_d == StFin);
            rd_data_q <= fb_q[rd_row];
            if (we) begin
                fb_q[waddr] <= wdata;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign vf      = {7'b0, vf_q};
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed plus randomized bench for sprite_engine: a wrapping and a clipping instance share
// stimulus and are checked against a pixel-level framebuffer model.
module tb_sprite_engine;

    logic         clk = 1'b0;
    logic         rst, clear_req, draw_req;
    logic [7:0]   row, col;
    logic [3:0]   height;
    logic [119:0] sprite_data;
    logic [4:0]   rd_row;
    logic         busy_w, done_w, busy_c, done_c;
    logic [7:0]   vf_w, vf_c;
    logic [63:0]  rd_w, rd_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Index 0 models the WRAP=1 instance, index 1 the WRAP=0 instance.
    logic [63:0] m_fb [2][32];
    logic        m_vf [2];

    always #5 clk = ~clk;

    sprite_engine #(.SCR_W(64), .SCR_H(32), .MAX_ROWS(15), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .clear_req(clear_req), .draw_req(draw_req), .row(row),
        .col(col), .height(height), .sprite_data(sprite_data), .busy(busy_w), .done(done_w),
        .vf(vf_w), .rd_row(rd_row), .rd_data(rd_w)
    );

    sprite_engine #(.SCR_W(64), .SCR_H(32), .MAX_ROWS(15), .WRAP(0)) dut_c (
        .clk(clk), .rst(rst), .clear_req(clear_req), .draw_req(draw_req), .row(row),
        .col(col), .height(height), .sprite_data(sprite_data), .busy(busy_c), .done(done_c),
        .vf(vf_c), .rd_row(rd_row), .rd_data(rd_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            for (int y = 0; y < 32; y++) m_fb[k][y] = '0;
        end
    endtask

    task automatic model_draw(input int r, input int c, input int h, input logic [119:0] d);
        int n, y, x;
        logic [7:0] b;
        n = (h > 15) ? 15 : h;
        for (int k = 0; k < 2; k++) begin
            m_vf[k] = 1'b0;
            for (int i = 0; i < n; i++) begin
                b = d[119-8*i -: 8];
                y = (r % 32) + i;
                if (k == 1 && y >= 32) continue;
                y = y % 32;
                for (int j = 0; j < 8; j++) begin
                    if (!b[7-j]) continue;
                    x = (c % 64) + j;
                    if (k == 1 && x >= 64) continue;
                    x = x % 64;
                    if (m_fb[k][y][x]) m_vf[k] = 1'b1;
                    m_fb[k][y][x] = ~m_fb[k][y][x];
                end
            end
        end
    endtask

    task automatic read_row(input int r);
        rd_row = r[4:0];
        @(negedge clk);
    endtask

    task automatic check_screen(input string tag);
        for (int r = 0; r < 32; r++) begin
            read_row(r);
            check($sformatf("%s wrap row %0d", tag, r), rd_w, m_fb[0][r]);
            check($sformatf("%s clip row %0d", tag, r), rd_c, m_fb[1][r]);
        end
    endtask

    task automatic start_draw(input int r, input int c, input int h, input logic [119:0] d);
        row         = r[7:0];
        col         = c[7:0];
        height      = h[3:0];
        sprite_data = d;
        draw_req    = 1'b1;
        @(posedge clk);
        #1 draw_req = 1'b0;
        model_draw(r, c, h, d);
    endtask

    task automatic finish_op(input string tag, input int exp_cycles);
        int cw = 0;
        int cc = 0;
        @(negedge clk);
        for (int t = 0; t < 100; t++) begin
            if (!busy_w && !busy_c) break;
            cw += int'(busy_w);
            cc += int'(busy_c);
            @(negedge clk);
        end
        check({tag, " busy cycles wrap"}, 64'(cw), 64'(exp_cycles));
        check({tag, " busy cycles clip"}, 64'(cc), 64'(exp_cycles));
        check({tag, " done wrap"}, 64'(done_w), 64'd1);
        check({tag, " done clip"}, 64'(done_c), 64'd1);
        check({tag, " vf wrap"}, 64'(vf_w), 64'(m_vf[0]));
        check({tag, " vf clip"}, 64'(vf_c), 64'(m_vf[1]));
        @(negedge clk);
        check({tag, " done drop"}, 64'({done_w, done_c}), 64'd0);
        check({tag, " idle busy"}, 64'({busy_w, busy_c}), 64'd0);
    endtask

    initial begin
        int r, c, h, cnt_w, cnt_c;
        logic [127:0] rnd;
        logic saw_done, saw_busy;

        rst = 1'b1; clear_req = 1'b0; draw_req = 1'b0;
        row = '0; col = '0; height = '0; sprite_data = '0; rd_row = '0;
        model_zero();
        m_vf[0] = 1'b0;
        m_vf[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset busy", 64'({busy_w, busy_c}), 64'd0);
        check("reset done", 64'({done_w, done_c}), 64'd0);
        check("reset vf wrap", 64'(vf_w), 64'd0);
        check("reset vf clip", 64'(vf_c), 64'd0);
        check("reset rd_data", rd_w | rd_c, 64'd0);
        check_screen("reset");

        // Single-row draw, then the same draw again erases it and collides.
        start_draw(0, 0, 1, {8'hF0, 112'b0});
        finish_op("draw f0", 1);
        read_row(0);
        check("row0 after f0", rd_w, 64'h000000000000000F);
        check("row0 after f0 model", rd_c, m_fb[1][0]);
        start_draw(0, 0, 1, {8'hF0, 112'b0});
        finish_op("redraw f0", 1);
        check("vf after redraw", 64'(vf_w), 64'd1);
        read_row(0);
        check("row0 erased", rd_w, 64'd0);

        // Corner draw exercising horizontal and vertical wrap versus clip.
        start_draw(31, 62, 2, {16'hFFFF, 104'b0});
        finish_op("corner", 2);
        read_row(31);
        check("corner row31 wrap", rd_w, 64'hC00000000000003F);
        check("corner row31 clip", rd_c, 64'hC000000000000000);
        read_row(0);
        check("corner row0 wrap", rd_w, 64'hC00000000000003F);
        check("corner row0 clip", rd_c, 64'd0);

        for (int it = 0; it < 24; it++) begin
            r   = int'($urandom_range(0, 255));
            c   = int'($urandom_range(0, 255));
            h   = int'($urandom_range(0, 15));
            rnd = {$urandom, $urandom, $urandom, $urandom};
            start_draw(r, c, h, rnd[119:0]);
            finish_op($sformatf("rand %0d", it), (h == 0) ? 1 : h);
        end
        check_screen("random");

        // Clear wins over a simultaneous draw; a draw pulsed mid-clear is ignored.
        clear_req   = 1'b1;
        draw_req    = 1'b1;
        row         = 8'd3;
        col         = 8'd3;
        height      = 4'd4;
        sprite_data = {32'hFFFFFFFF, 88'b0};
        @(posedge clk);
        #1 clear_req = 1'b0;
        draw_req = 1'b0;
        cnt_w = 0;
        cnt_c = 0;
        saw_done = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 100; t++) begin
            if (!busy_w && !busy_c) break;
            cnt_w += int'(busy_w);
            cnt_c += int'(busy_c);
            saw_done |= done_w | done_c;
            draw_req = (cnt_w == 10);
            @(negedge clk);
        end
        draw_req = 1'b0;
        check("clear busy cycles wrap", 64'(cnt_w), 64'd32);
        check("clear busy cycles clip", 64'(cnt_c), 64'd32);
        check("clear done early", 64'(saw_done), 64'd0);
        check("clear done", 64'({done_w, done_c}), 64'b11);
        check("clear vf wrap kept", 64'(vf_w), 64'(m_vf[0]));
        check("clear vf clip kept", 64'(vf_c), 64'(m_vf[1]));
        @(negedge clk);
        check("clear done drop", 64'({done_w, done_c}), 64'd0);
        @(negedge clk);
        check("clear no late draw", 64'({busy_w, busy_c}), 64'd0);
        model_zero();
        check_screen("after clear");

        // height=0 still takes one cycle and resets vf.
        start_draw(5, 5, 1, {8'hFF, 112'b0});
        finish_op("pre h0 a", 1);
        start_draw(5, 5, 1, {8'hFF, 112'b0});
        finish_op("pre h0 b", 1);
        start_draw(5, 5, 1, {8'h3C, 112'b0});
        finish_op("pre h0 c", 1);
        start_draw(5, 6, 0, {8'hFF, 112'b0});
        finish_op("h0", 1);
        check_screen("h0");

        // Reset on the 5th busy cycle of a 15-row draw aborts it.
        rnd = {$urandom, $urandom, $urandom, $urandom};
        start_draw(7, 9, 15, rnd[119:0]);
        cnt_w = 0;
        @(negedge clk);
        for (int t = 0; t < 50; t++) begin
            if (!busy_w) break;
            cnt_w++;
            if (cnt_w == 5) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("abort reached 5th cycle", 64'(cnt_w), 64'd5);
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_done |= done_w | done_c;
            saw_busy |= busy_w | busy_c;
        end
        check("abort no done", 64'(saw_done), 64'd0);
        check("abort busy low", 64'(saw_busy), 64'd0);
        check("abort vf", 64'({vf_w, vf_c}), 64'd0);
        model_zero();
        check_screen("abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
